// File: rtl/spi_ram_master_ctrl.sv
// Host-side SPI master that turns one byte read/write request into an address
// frame followed by a data frame, capturing MISO for reads.
module spi_ram_master_ctrl #(
  parameter int GAP_CYC = 2,
  parameter int RD_WAIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_op,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_SHIFT,
    S_TURN,
    S_CAPTURE,
    S_GAP
  } state_t;

  localparam logic       PH_ADDR   = 1'b0;
  localparam logic       PH_DATA   = 1'b1;
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYC - 1);
  localparam logic [7:0] TURN_LAST = 8'(RD_WAIT - 1);

  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic        op_q, op_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        ss_n_q, ss_n_d;
  logic        mosi_q, mosi_d;
  logic        accept;
  logic [1:0]  cmd_d;
  logic [9:0]  frame_d;

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= PH_ADDR;
      op_q        <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      bit_cnt_q   <= 4'd0;
      wait_cnt_q  <= 8'd0;
      shreg_q     <= 8'h00;
      rdata_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      bit_cnt_q   <= bit_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      shreg_q     <= shreg_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SEL;
          phase_d = PH_ADDR;
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      S_SEL: begin
        if (wait_cnt_q == 8'd1) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (bit_cnt_q == 4'd9) begin
          state_d = (op_q && (phase_q == PH_DATA)) ? S_TURN : S_GAP;
        end
      end
      S_TURN: begin
        if (wait_cnt_q == TURN_LAST) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (wait_cnt_q == 8'd7) state_d = S_GAP;
      end
      S_GAP: begin
        if (wait_cnt_q == GAP_LAST) begin
          if (phase_q == PH_ADDR) begin
            phase_d = PH_DATA;
            state_d = S_SEL;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Counters restart on every state entry, so no count leaks between states
    bit_cnt_d  = 4'd0;
    wait_cnt_d = 8'd0;
    if (state_d == state_q) begin
      if (state_q == S_SHIFT) begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else if (state_q != S_IDLE) begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end

    shreg_d = shreg_q;
    rdata_d = rdata_q;
    if (state_q == S_CAPTURE) begin
      shreg_d = {shreg_q[6:0], MISO};
      if (wait_cnt_q == 8'd7) rdata_d = {shreg_q[6:0], MISO};
    end
  end

  // Outputs are decoded from the next state so SS_n/MOSI come straight from flops
  always_comb begin
    cmd_d       = {op_d, phase_d};
    frame_d     = {cmd_d, (phase_d == PH_ADDR) ? addr_d : (op_d ? 8'h00 : wdata_d)};
    ss_n_d      = 1'b1;
    mosi_d      = 1'b0;
    rsp_valid_d = (state_q == S_GAP) && (state_d == S_IDLE);
    case (state_d)
      S_SEL: begin
        ss_n_d = 1'b0;
        mosi_d = cmd_d[1];
      end
      S_SHIFT: begin
        ss_n_d = 1'b0;
        mosi_d = frame_d[4'd9 - bit_cnt_d];
      end
      S_TURN, S_CAPTURE: begin
        ss_n_d = 1'b0;
      end
      default: begin
        ss_n_d = 1'b1;
        mosi_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_ram_master_ctrl.sv
// Self-checking bench for spi_ram_master_ctrl: table vectors, hand sequences
// for back-to-back, busy rejection and reset, then random transactions.
module tb_spi_ram_master_ctrl;

  localparam int GAP_CYC = 2;
  localparam int RD_WAIT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_op;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  always #5 clk = ~clk;

  spi_ram_master_ctrl #(.GAP_CYC(GAP_CYC), .RD_WAIT(RD_WAIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  typedef struct {
    bit         op;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] miso;
    logic [7:0] exp_rdata;
    int         exp_lat;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          txn_id   = 0;
  logic [7:0]  model_rdata;
  logic [63:0] last_mosi;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] take12(input logic [63:0] v, input int s);
    logic [11:0] r;
    for (int i = 0; i < 12; i++) r[11-i] = v[s+i];
    return r;
  endfunction

  // Reference: list of expected (SS_n, MOSI) per cycle after accept, built frame by frame
  task automatic build_exp(input bit op, input logic [7:0] addr, input logic [7:0] wdata,
                           output logic [63:0] ess, output logic [63:0] emosi,
                           output logic [63:0] ecare, output int lat, output int cap0);
    logic [1:0] cmd;
    logic [9:0] word;
    int c;
    ess = '1; emosi = '0; ecare = '0; c = 1; cap0 = 0;
    for (int ph = 0; ph < 2; ph++) begin
      cmd  = {op, ph[0]};
      word = {cmd, (ph == 0) ? addr : (op ? 8'h00 : wdata)};
      for (int i = 0; i < 2; i++) begin
        ess[c] = 1'b0; emosi[c] = cmd[1]; ecare[c] = 1'b1; c++;
      end
      for (int b = 9; b >= 0; b--) begin
        ess[c] = 1'b0; emosi[c] = word[b]; ecare[c] = 1'b1; c++;
      end
      if (op && ph == 1) begin
        for (int i = 0; i < RD_WAIT; i++) begin
          ess[c] = 1'b0; emosi[c] = 1'b0; ecare[c] = 1'b1; c++;
        end
        cap0 = c;
        for (int i = 0; i < 8; i++) begin
          ess[c] = 1'b0; c++;
        end
      end
      for (int i = 0; i < GAP_CYC; i++) begin
        ess[c] = 1'b1; emosi[c] = 1'b0; ecare[c] = 1'b1; c++;
      end
    end
    ess[c] = 1'b1; emosi[c] = 1'b0; ecare[c] = 1'b1;
    lat = c;
  endtask

  // Starts between a negedge and the next posedge; returns at the negedge of the rsp cycle
  task automatic run_txn(input bit op, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [7:0] miso_byte, input logic [7:0] exp_rdata,
                         input int exp_lat, input bit perturb);
    logic [63:0] ess, emosi, ecare, ass, amosi, mask;
    int lat, cap0, rsp_at, busy_bad, ready_bad;
    build_exp(op, addr, wdata, ess, emosi, ecare, lat, cap0);
    ass = '1; amosi = '0; mask = '0;
    rsp_at = 0; busy_bad = 0; ready_bad = 0;
    for (int k = 1; k <= lat; k++) mask[k] = 1'b1;
    req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    #1;
    check("req_ready_at_accept", req_ready, 1);
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      if (k < 64) begin
        ass[k]   = SS_n;
        amosi[k] = MOSI;
      end
      if (busy !== (k < exp_lat)) busy_bad++;
      if (req_ready !== (k == exp_lat)) ready_bad++;
      if (rsp_valid === 1'b1) begin
        rsp_at = k;
        break;
      end
      if (op && cap0 != 0 && k >= cap0 && k < cap0 + 8) MISO = miso_byte[7-(k-cap0)];
      else MISO = 1'($urandom_range(0, 1));
      if (perturb) begin
        req_valid = 1'($urandom_range(0, 1));
        req_op    = 1'($urandom_range(0, 1));
        req_addr  = 8'($urandom);
        req_wdata = 8'($urandom);
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("rsp_cycle", rsp_at, exp_lat);
    check("ss_n_wave", ass & mask, ess & mask);
    check("mosi_wave", amosi & ecare, emosi & ecare);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("busy_wave_errs", busy_bad, 0);
    check("ready_wave_errs", ready_bad, 0);
    last_mosi = amosi;
    $display("txn %0d: %s addr=%02h wdata=%02h miso=%02h rsp_cycle=%0d rdata=%02h",
             txn_id, op ? "RD" : "WR", addr, wdata, miso_byte, rsp_at, rsp_rdata);
    txn_id++;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check("rst_ss_n", SS_n, 1);
    check("rst_mosi", MOSI, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    bit         r_op;
    logic [7:0] r_addr, r_wdata, r_miso, r_exp;
    int         r_lat;

    vecs[0] = '{1'b0, 8'h3C, 8'hA5, 8'h00, 8'h00, 29};
    vecs[1] = '{1'b1, 8'h3C, 8'h00, 8'hA5, 8'hA5, 40};
    vecs[2] = '{1'b0, 8'hFF, 8'h00, 8'h00, 8'hA5, 29};
    vecs[3] = '{1'b1, 8'h00, 8'hFF, 8'h5A, 8'h5A, 40};
    vecs[4] = '{1'b1, 8'h81, 8'h12, 8'hFF, 8'hFF, 40};
    vecs[5] = '{1'b0, 8'h01, 8'h7E, 8'h00, 8'hFF, 29};

    rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    MISO = 1'b0; model_rdata = 8'h00;
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs();
    end
    rst = 1'b0;
    #1;
    check("ready_after_reset", req_ready, 1);

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].miso,
              vecs[i].exp_rdata, vecs[i].exp_lat, 1'b0);
      model_rdata = vecs[i].exp_rdata;
      if (i == 0) begin
        check("wr_addr_frame_bits", take12(last_mosi, 1), 12'b0000_0011_1100);
        check("wr_data_frame_bits", take12(last_mosi, 15), 12'b0001_1010_0101);
      end
      if (i == 1) begin
        check("rd_addr_frame_bits", take12(last_mosi, 1), 12'b1110_0011_1100);
        check("rd_data_frame_bits", take12(last_mosi, 15), 12'b1111_0000_0000);
      end
      idle(2);
    end

    // Back-to-back: second request accepted on the rsp_valid cycle
    run_txn(1'b0, 8'h10, 8'h5A, 8'h00, model_rdata, 29, 1'b0);
    run_txn(1'b1, 8'h10, 8'h00, 8'h3C, 8'h3C, 40, 1'b0);
    model_rdata = 8'h3C;
    idle(1);

    // Requests toggled while busy must be ignored
    run_txn(1'b0, 8'h3C, 8'hA5, 8'h00, model_rdata, 29, 1'b1);
    idle(2);
    check("no_stray_accept_busy", busy, 0);
    check("no_stray_accept_ss_n", SS_n, 1);

    // Reset in cycle 32 of a read
    req_op = 1'b1; req_addr = 8'h77; req_wdata = 8'h00; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      MISO = 1'($urandom_range(0, 1));
      if (k == 32) rst = 1'b1;
    end
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs();
    end
    rst = 1'b0;
    #1;
    check("ready_after_midread_reset", req_ready, 1);
    model_rdata = 8'h00;
    run_txn(1'b1, 8'h3C, 8'h00, 8'hC3, 8'hC3, 40, 1'b0);
    model_rdata = 8'hC3;
    idle(1);

    for (int n = 0; n < 24; n++) begin
      r_op    = 1'($urandom_range(0, 1));
      r_addr  = 8'($urandom);
      r_wdata = 8'($urandom);
      r_miso  = 8'($urandom);
      r_lat   = r_op ? (33 + RD_WAIT + 2 * GAP_CYC) : (25 + 2 * GAP_CYC);
      r_exp   = r_op ? r_miso : model_rdata;
      run_txn(r_op, r_addr, r_wdata, r_miso, r_exp, r_lat, 1'($urandom_range(0, 1)));
      model_rdata = r_exp;
      idle($urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
